usb_hid_report_tx: RTL and testbench
====================================

// Module: usb_hid_report_tx
// PURPOSE
//  Device-side HID report serializer: the transmit counterpart of the HID host receiver path.
//  Snapshots keyboard/mouse/LED state, builds a boot-protocol report, appends USB CRC-16 and
//  streams bytes with rdy/stb framing identical to the host byte interface (rdy frames, one stb per byte).
//  Used as a device model for loopback benches and as the packet-body source for a future device PHY.
// PARAMETERS
//  STB_HIGH    4  cycles tx_stb is high per byte (>=1)
//  STB_LOW     4  cycles tx_stb is low after each byte, and lead-in after tx_rdy rise (>=1)
//  APPEND_CRC  1  1: append 2 CRC bytes (low byte first); 0: report bytes only
// PORTS
//  usbclk         in   1  clock
//  usbrst         in   1  asynchronous active-high reset
//  send_stb       in   1  1-cycle request; accepted only in IDLE
//  typ            in   2  1=keyboard(8B) 2=mouse(3B) 3=LED/raw(1B) 0=none(ignored)
//  key_modifiers  in   8  kbd byte0; also the single raw byte for typ=3
//  key1..key4     in   8  kbd bytes 2..5 (four ports)
//  mouse_btn      in   8  mouse byte0
//  mouse_dx       in   8  mouse byte1, signed two's complement, passed unmodified
//  mouse_dy       in   8  mouse byte2, signed, passed unmodified
//  busy           out  1  high from accept until done_stb cycle inclusive
//  done_stb       out  1  1-cycle pulse when frame ends
//  tx_rdy         out  1  frame envelope
//  tx_stb         out  1  byte strobe; tx_dat valid whole time tx_stb high
//  tx_dat         out  8  current byte
//  crc_o          out 16  final CRC of last frame (complemented), held until next accept
// BEHAVIOUR
//  Reset async, all outputs 0, FSM to IDLE, snapshot regs 0. Reset mid-frame aborts instantly; no done_stb.
//  Clocking: usbclk only, single domain.
//  FSM: IDLE -> LEAD -> HIGH <-> LOW -> DONE -> IDLE.
//   IDLE: send_stb=1 and typ!=0 -> snapshot all inputs + typ, busy=1, tx_rdy=1 next cycle, go LEAD.
//         typ==0 -> request dropped, no output activity.
//   LEAD: STB_LOW cycles, tx_stb=0, tx_dat=byte0.
//   HIGH: STB_HIGH cycles, tx_stb=1, tx_dat=byte[idx]; CRC updated with byte[idx] on HIGH entry.
//   LOW:  STB_LOW cycles, tx_stb=0; idx++; if idx==total_len go DONE else HIGH with next byte.
//   DONE: tx_rdy=0, done_stb=1, busy=1 this cycle; IDLE next cycle.
//  First tx_stb rise = accept cycle + 1 + STB_LOW. tx_rdy falls after last LOW phase.
//  Layout: kbd = {mod,00,k1,k2,k3,k4,00,00}; mouse = {btn,dx,dy}; LED/raw = {mod}.
//  total_len = report_len + (APPEND_CRC ? 2 : 0). CRC bytes: ~crc[7:0] then ~crc[15:8].
//  CRC-16 USB: poly x^16+x^15+x^2+1, reflected (0xA001), init 0xFFFF, bytes processed LSB first.
//   Output complemented. Byte-wide combinational update (8 unrolled steps); CRC bytes not fed back.
//  send_stb while busy: ignored, no queueing. Input changes after accept: no effect on frame.
//  crc_o loads at DONE (also with APPEND_CRC=0).
//  send_stb in the same cycle DONE->IDLE is ignored; accepted earliest on the first IDLE cycle.
//  Counters sized to max(STB_HIGH,STB_LOW); idx 4 bits (max 10 bytes), never wraps.
// TESTING
//  1 typ=3, mod=0x00, send -> bytes 00,40,BF; crc_o=BF40; done_stb 1 pulse; busy drops after.
//  2 typ=3, mod=0x01 -> 01,81,7F; mod=0x0F -> 0F,00,BB (matches host LED CRC table).
//  3 typ=1, mod=0x02, k1=0x04 -> 02,00,04,00,00,00,00,00 + 2 CRC bytes == bitwise LFSR model;
//    feed to host receiver in loopback -> key_modifiers=02, key1=04, report pulse.
//  4 typ=2, btn=01, dx=0xFF(-1), dy=0x05 -> 01,FF,05 + CRC; host sees mouse_dx=-1.
//  5 Timing, STB_HIGH=2, STB_LOW=3: first stb rise at accept+4; stb period 5; send_stb mid-frame ignored.
//  6 Assert usbrst during byte 3 of kbd frame -> all outputs 0 immediately; next send gives clean frame.
//    typ=0 send -> no tx_rdy.

Source files
------------

// File: rtl/usb_hid_report_tx.sv
// HID boot-protocol report serializer: snapshots kbd/mouse/LED state and streams the report
// plus optional USB CRC-16 over a rdy/stb byte interface.
module usb_hid_report_tx #(
   parameter int STB_HIGH   = 4,
   parameter int STB_LOW    = 4,
   parameter bit APPEND_CRC = 1'b1
) (
   input  logic        usbclk,
   input  logic        usbrst,
   input  logic        send_stb,
   input  logic [1:0]  typ,
   input  logic [7:0]  key_modifiers,
   input  logic [7:0]  key1,
   input  logic [7:0]  key2,
   input  logic [7:0]  key3,
   input  logic [7:0]  key4,
   input  logic [7:0]  mouse_btn,
   input  logic [7:0]  mouse_dx,
   input  logic [7:0]  mouse_dy,
   output logic        busy,
   output logic        done_stb,
   output logic        tx_rdy,
   output logic        tx_stb,
   output logic [7:0]  tx_dat,
   output logic [15:0] crc_o
);

   localparam int CMAX = (STB_HIGH > STB_LOW) ? STB_HIGH : STB_LOW;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam logic [CW-1:0] HIGH_LAST = CW'(STB_HIGH - 1);
   localparam logic [CW-1:0] LOW_LAST  = CW'(STB_LOW - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEAD,
      S_HIGH,
      S_LOW,
      S_DONE
   } state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt;
   logic [3:0]     idx;
   logic [15:0]    crc;
   logic [1:0]     s_typ;
   logic [7:0]     s_mod, s_k1, s_k2, s_k3, s_k4, s_btn, s_dx, s_dy;
   logic [3:0]     rep_len, total_len;
   logic [7:0]     rep_byte, cur_byte;
   logic           accept, last_byte;

   // Reflected CRC-16/USB (poly 0xA001), one byte LSB first, unrolled to 8 steps.
   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int i = 0; i < 8; i++) begin
         fb = r[0] ^ d[i];
         r  = {1'b0, r[15:1]};
         if (fb) r = r ^ 16'hA001;
      end
      return r;
   endfunction

   assign accept = (state == S_IDLE) && send_stb && (typ != 2'd0);

   always_comb begin
      rep_len = 4'd0;
      case (s_typ)
         2'd1:    rep_len = 4'd8;
         2'd2:    rep_len = 4'd3;
         2'd3:    rep_len = 4'd1;
         default: rep_len = 4'd0;
      endcase
   end

   assign total_len = rep_len + (APPEND_CRC ? 4'd2 : 4'd0);
   assign last_byte = (4'(idx + 4'd1) == total_len);

   always_comb begin
      rep_byte = 8'h00;
      case (s_typ)
         2'd1: begin
            case (idx)
               4'd0:    rep_byte = s_mod;
               4'd2:    rep_byte = s_k1;
               4'd3:    rep_byte = s_k2;
               4'd4:    rep_byte = s_k3;
               4'd5:    rep_byte = s_k4;
               default: rep_byte = 8'h00;
            endcase
         end
         2'd2: begin
            case (idx)
               4'd0:    rep_byte = s_btn;
               4'd1:    rep_byte = s_dx;
               4'd2:    rep_byte = s_dy;
               default: rep_byte = 8'h00;
            endcase
         end
         2'd3:    rep_byte = s_mod;
         default: rep_byte = 8'h00;
      endcase
   end

   // CRC bytes follow the report; crc is frozen by then so ~crc is stable while they are sent.
   always_comb begin
      cur_byte = rep_byte;
      if (idx == rep_len)
         cur_byte = ~crc[7:0];
      else if (idx > rep_len)
         cur_byte = ~crc[15:8];
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = S_LEAD;
         S_LEAD: if (cnt == LOW_LAST) state_nxt = S_HIGH;
         S_HIGH: if (cnt == HIGH_LAST) state_nxt = S_LOW;
         S_LOW:  if (cnt == LOW_LAST) state_nxt = last_byte ? S_DONE : S_HIGH;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge usbclk or posedge usbrst) begin
      if (usbrst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state || state == S_IDLE || state == S_DONE)
            cnt <= '0;
         else
            cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge usbclk or posedge usbrst) begin
      if (usbrst) begin
         idx   <= 4'd0;
         crc   <= 16'h0000;
         crc_o <= 16'h0000;
         s_typ <= 2'd0;
         s_mod <= 8'h00;
         s_k1  <= 8'h00;
         s_k2  <= 8'h00;
         s_k3  <= 8'h00;
         s_k4  <= 8'h00;
         s_btn <= 8'h00;
         s_dx  <= 8'h00;
         s_dy  <= 8'h00;
      end else begin
         if (accept) begin
            idx   <= 4'd0;
            crc   <= 16'hFFFF;
            s_typ <= typ;
            s_mod <= key_modifiers;
            s_k1  <= key1;
            s_k2  <= key2;
            s_k3  <= key3;
            s_k4  <= key4;
            s_btn <= mouse_btn;
            s_dx  <= mouse_dx;
            s_dy  <= mouse_dy;
         end
         if (state == S_HIGH && cnt == '0 && idx < rep_len)
            crc <= crc_step(crc, rep_byte);
         if (state == S_LOW && state_nxt == S_HIGH)
            idx <= idx + 4'd1;
         // Load on DONE entry so crc_o is already valid while done_stb is high.
         if (state_nxt == S_DONE && state == S_LOW)
            crc_o <= ~crc;
      end
   end

   assign busy     = (state != S_IDLE);
   assign done_stb = (state == S_DONE);
   assign tx_rdy   = (state == S_LEAD) || (state == S_HIGH) || (state == S_LOW);
   assign tx_stb   = (state == S_HIGH);
   assign tx_dat   = tx_rdy ? cur_byte : 8'h00;

endmodule

// File: tb/tb_usb_hid_report_tx.sv
// Scoreboard bench for usb_hid_report_tx: stimulus queues expected bytes/CRC, monitor checks them.
module tb_usb_hid_report_tx;

   logic        usbclk = 1'b0;
   logic        usbrst = 1'b1;
   logic        send_stb = 1'b0;
   logic [1:0]  typ = 2'd0;
   logic [7:0]  key_modifiers = 8'h00, key1 = 8'h00, key2 = 8'h00, key3 = 8'h00, key4 = 8'h00;
   logic [7:0]  mouse_btn = 8'h00, mouse_dx = 8'h00, mouse_dy = 8'h00;
   logic        busy, done_stb, tx_rdy, tx_stb;
   logic [7:0]  tx_dat;
   logic [15:0] crc_o;

   int total = 0;
   int bad   = 0;
   int nbytes = 0;
   logic [7:0]  byte_q[$];
   logic [15:0] crc_q[$];
   logic        prev_stb = 1'b0;

   usb_hid_report_tx #(.STB_HIGH(2), .STB_LOW(3), .APPEND_CRC(1'b1)) dut (
      .usbclk(usbclk), .usbrst(usbrst), .send_stb(send_stb), .typ(typ),
      .key_modifiers(key_modifiers), .key1(key1), .key2(key2), .key3(key3), .key4(key4),
      .mouse_btn(mouse_btn), .mouse_dx(mouse_dx), .mouse_dy(mouse_dy),
      .busy(busy), .done_stb(done_stb), .tx_rdy(tx_rdy), .tx_stb(tx_stb),
      .tx_dat(tx_dat), .crc_o(crc_o)
   );

   always #5 usbclk = ~usbclk;

   function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] d);
      logic fb;
      for (int i = 0; i < 8; i++) begin
         fb = c[0] ^ d[i];
         c  = c >> 1;
         if (fb) c = c ^ 16'hA001;
      end
      return c;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: byte checked on each tx_stb rise, CRC checked during done_stb.
   always @(negedge usbclk) begin
      if (tx_stb && !prev_stb) begin
         total++;
         nbytes++;
         if (byte_q.size() == 0) begin
            bad++;
            $display("FAIL byte: unexpected byte %h", tx_dat);
         end else begin
            logic [7:0] e;
            e = byte_q.pop_front();
            if (tx_dat !== e) begin
               bad++;
               $display("FAIL byte: got %h expected %h", tx_dat, e);
            end
         end
      end
      if (done_stb) begin
         total++;
         if (crc_q.size() == 0) begin
            bad++;
            $display("FAIL done: unexpected done_stb, crc_o %h", crc_o);
         end else begin
            logic [15:0] e;
            e = crc_q.pop_front();
            if (crc_o !== e) begin
               bad++;
               $display("FAIL crc_o: got %h expected %h", crc_o, e);
            end
         end
      end
      prev_stb = tx_stb;
   end

   task automatic issue(input logic [1:0] t, input logic [7:0] m, input logic [7:0] k1,
                        input logic [7:0] btn, input logic [7:0] dx, input logic [7:0] dy);
      @(posedge usbclk); #1;
      send_stb = 1'b1; typ = t; key_modifiers = m; key1 = k1;
      key2 = 8'h00; key3 = 8'h00; key4 = 8'h00;
      mouse_btn = btn; mouse_dx = dx; mouse_dy = dy;
      @(posedge usbclk); #1;
      // Scramble inputs after accept; the frame must come from the snapshot.
      send_stb = 1'b0; key_modifiers = 8'hA5; key1 = 8'h5A; key2 = 8'h33;
      mouse_btn = 8'hC3; mouse_dx = 8'h3C; mouse_dy = 8'h99;
   endtask

   task automatic push_model(input logic [1:0] t, input logic [7:0] m, input logic [7:0] k1,
                             input logic [7:0] btn, input logic [7:0] dx, input logic [7:0] dy);
      logic [7:0]  rep[$];
      logic [15:0] c;
      if (t == 2'd1) rep = '{m, 8'h00, k1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      else if (t == 2'd2) rep = '{btn, dx, dy};
      else rep = '{m};
      c = 16'hFFFF;
      foreach (rep[i]) begin
         c = crc_model(c, rep[i]);
         byte_q.push_back(rep[i]);
      end
      c = ~c;
      byte_q.push_back(c[7:0]);
      byte_q.push_back(c[15:8]);
      crc_q.push_back(c);
   endtask

   task automatic push_hand(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      byte_q.push_back(b0);
      byte_q.push_back(b1);
      byte_q.push_back(b2);
      crc_q.push_back({b2, b1});
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 400) begin
         @(posedge usbclk); #1;
         n++;
      end
      check({name, "_idle_timeout"}, 32'(n >= 400), 32'd0);
      check({name, "_after"}, {busy, tx_rdy, tx_stb}, 3'b000);
   endtask

   initial begin
      int n;
      logic saw_rdy;
      #12;
      check("reset_outputs", {busy, done_stb, tx_rdy, tx_stb, tx_dat, crc_o}, 28'h0);
      #1 usbrst = 1'b0;

      // LED/raw reports, hand-computed CRC
      push_hand(8'h00, 8'h40, 8'hBF);
      issue(2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      check("busy_after_accept", {busy, tx_rdy}, 2'b11);
      wait_idle("led00");
      push_hand(8'h01, 8'h81, 8'h7F);
      issue(2'd3, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
      wait_idle("led01");
      push_hand(8'h0F, 8'h00, 8'hBB);
      issue(2'd3, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00);
      wait_idle("led0f");

      // Keyboard and mouse reports against the bitwise model
      push_model(2'd1, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00);
      issue(2'd1, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00);
      wait_idle("kbd");
      push_model(2'd2, 8'h00, 8'h00, 8'h01, 8'hFF, 8'h05);
      issue(2'd2, 8'h00, 8'h00, 8'h01, 8'hFF, 8'h05);
      wait_idle("mouse");

      // Timing: first rise accept+4, period 5, send_stb mid-frame ignored
      push_model(2'd2, 8'h00, 8'h00, 8'h80, 8'h7F, 8'h80);
      issue(2'd2, 8'h00, 8'h00, 8'h80, 8'h7F, 8'h80);
      n = 0;
      while (!tx_stb && n < 50) begin @(posedge usbclk); #1; n++; end
      check("first_rise_edges", n, 3);
      send_stb = 1'b1; typ = 2'd3;
      @(posedge usbclk); #1;
      send_stb = 1'b0;
      n = 1;
      while (tx_stb && n < 50) begin @(posedge usbclk); #1; n++; end
      while (!tx_stb && n < 50) begin @(posedge usbclk); #1; n++; end
      check("stb_period", n, 5);
      wait_idle("timing");

      // Reset during byte 3 of a keyboard frame
      push_model(2'd1, 8'hE1, 8'h1E, 8'h00, 8'h00, 8'h00);
      n = nbytes;
      issue(2'd1, 8'hE1, 8'h1E, 8'h00, 8'h00, 8'h00);
      while (nbytes < n + 3 && !(usbrst)) begin
         @(negedge usbclk);
         if ($time > 200000) break;
      end
      check("reached_byte3", nbytes, n + 3);
      #2 usbrst = 1'b1;
      #1 check("midframe_reset", {busy, done_stb, tx_rdy, tx_stb, tx_dat, crc_o}, 28'h0);
      byte_q.delete();
      crc_q.delete();
      @(posedge usbclk); @(posedge usbclk); #1 usbrst = 1'b0;
      push_model(2'd1, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00);
      issue(2'd1, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00);
      wait_idle("post_reset");

      // typ=0 dropped
      issue(2'd0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
      saw_rdy = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (tx_rdy || busy) saw_rdy = 1'b1;
         @(posedge usbclk); #1;
      end
      check("typ0_no_activity", saw_rdy, 1'b0);

      check("byte_q_drained", byte_q.size(), 0);
      check("crc_q_drained", crc_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
